sum_display_scanner: RTL

Parametrised successor of the 3-bit sum calculator. Holds two WIDTH-bit operands and a (WIDTH+1)-bit accumulator, and executes load/add/accumulate/clear commands. It converts a selected value to decimal with a sequential double-dabble engine and drives a time-multiplexed DIGITS-digit common 7-segment display. It sits between switch/button input logic and the board display pins.

---
 rtl/sum_display_scanner.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sum_display_scanner.sv
// Operand/accumulator unit with a scanned 7-segment readout.
// SUM_DISPLAY_BCD_EN selects the decimal converter; otherwise hex digits.
module sum_display_scanner #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  num_A,
  input  logic [WIDTH-1:0]  num_B,
  input  logic              op_valid,
  input  logic [1:0]        op_sel,
  input  logic [1:0]        num_selected,
  output logic [6:0]        display,
  output logic [DIGITS-1:0] digit_en,
  output logic              carry,
  output logic              ovf_disp,
  output logic              busy
);

  localparam int VW  = WIDTH + 1;
  localparam int NB  = ((VW + 2) / 3 > DIGITS) ? (VW + 2) / 3 : DIGITS;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [VW-1:0]       acc_q;
  logic                carry_q;
  logic [VW:0]         acc_sum;
  logic [VW-1:0]       src_q, src_d;
  logic [4*DIGITS-1:0] dig_q;
  logic                ovf_q;
  logic [DIGITS-1:0]   lit;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q;
  logic [6:0]          disp_q;
  logic [DIGITS-1:0]   en_q;

  assign acc_sum = {1'b0, acc_q} + {2'b0, num_A};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (op_valid) begin
      unique case (op_sel)
        2'b00: acc_q <= {1'b0, num_A};
        2'b01: acc_q <= {1'b0, num_A} + {1'b0, num_B};
        2'b10: begin
          acc_q <= acc_sum[VW-1:0];
          if (acc_sum[VW]) carry_q <= 1'b1;
        end
        default: begin
          acc_q   <= '0;
          carry_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    src_d = '0;
    unique case (num_selected)
      2'b00:   src_d = {1'b0, num_A};
      2'b01:   src_d = {1'b0, num_B};
      2'b10:   src_d = acc_q;
      default: src_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) src_q <= '0;
    else     src_q <= src_d;
  end

`ifdef SUM_DISPLAY_BCD_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} st_t;
  localparam int SW  = 4 * NB + VW;
  localparam int ITW = $clog2(VW + 1);

  st_t            st_q, st_d;
  logic [SW-1:0]  sh_q, sh_d;
  logic [ITW-1:0] it_q, it_d;
  logic [VW-1:0]  last_q;
  logic           start;

  function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int i = 0; i < NB; i++) begin
      if (t[VW+4*i +: 4] >= 4'd5)
        t[VW+4*i +: 4] = t[VW+4*i +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  assign start = (st_q == IDLE) && (src_q != last_q);

  always_comb begin
    st_d = st_q;
    sh_d = sh_q;
    it_d = it_q;
    unique case (st_q)
      IDLE: if (start) begin
        sh_d = {{4*NB{1'b0}}, src_q};
        it_d = '0;
        st_d = SHIFT;
      end
      SHIFT: begin
        sh_d = dabble(sh_q);
        it_d = it_q + 1'b1;
        if (it_q == ITW'(VW - 1)) st_d = DONE;
      end
      default: st_d = IDLE;
    endcase
  end

  // last_q tracks the value under conversion so a mid-shift change re-triggers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      sh_q   <= '0;
      it_q   <= '0;
      last_q <= '0;
      dig_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      st_q <= st_d;
      sh_q <= sh_d;
      it_q <= it_d;
      if (start) last_q <= src_q;
      if (st_q == DONE) begin
        dig_q <= sh_q[VW +: 4*DIGITS];
        ovf_q <= |(sh_q[SW-1:VW] >> 4*DIGITS);
      end
    end
  end

  assign busy = (st_q != IDLE);
`else
  logic [4*NB-1:0] hex;
  assign hex = (4*NB)'(src_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      dig_q <= hex[4*DIGITS-1:0];
      ovf_q <= |(hex >> 4*DIGITS);
    end
  end

  assign busy = 1'b0;
`endif

  always_comb begin
    lit = '0;
    lit[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++)
      lit[i] = |(dig_q >> 4*i);
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      disp_q <= 7'b0111111;
      en_q   <= DIGITS'(1);
    end else begin
      if (cnt_q == CW'(SCAN_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      en_q <= DIGITS'(1) << idx_q;
      if (num_selected == 2'b11 || !lit[idx_q])
        disp_q <= 7'b0;
      else
        disp_q <= seg7(dig_q[4*idx_q +: 4]);
    end
  end

  assign display  = disp_q;
  assign digit_en = en_q;
  assign carry    = carry_q;
  assign ovf_disp = ovf_q;

endmodule
